alu_mc: RTL

Parametrised multi-cycle ALU for the MIPS_CPU datapath. It succeeds the 2-bit-option combinational ALU and keeps that ALU's ADD/SUB/AND/OR encodings. It adds SLT, XOR, unsigned multiply and unsigned divide, with HI/LO results, status flags and a start/busy/done handshake. Single-cycle ops complete in 1 cycle; multiply/divide iterate over WIDTH cycles, so the control unit must stall on `busy`.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_muldiv_iter.sv | 76 +++++++
 rtl/alu_mc.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
   localparam logic [OP_W-1:0] OP_AND   = 3'b010;
   localparam logic [OP_W-1:0] OP_OR    = 3'b011;
   localparam logic [OP_W-1:0] OP_SLT   = 3'b100;
   localparam logic [OP_W-1:0] OP_XOR   = 3'b101;
   localparam logic [OP_W-1:0] OP_MULTU = 3'b110;
   localparam logic [OP_W-1:0] OP_DIVU  = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_RUN
   } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
// lo/hi present the result of the step being taken this cycle; valid when fin=1.
module alu_muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             fin,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] opnd_q;
   logic             div_q;
   logic             run_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   msum;
   logic [WIDTH:0]   dshift;
   logic [WIDTH:0]   ddiff;

   always_comb begin
      msum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
      dshift = {acc_q, sh_q[WIDTH-1]};
      ddiff  = dshift - {1'b0, opnd_q};
      acc_d  = msum[WIDTH:1];
      sh_d   = {msum[0], sh_q[WIDTH-1:1]};
      if (div_q) begin
         // Restore (keep the shifted remainder) when the trial subtraction borrows.
         if (!ddiff[WIDTH]) begin
            acc_d = ddiff[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = dshift[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign fin = run_q && (cnt_q == LAST);
   assign lo  = sh_d;
   assign hi  = acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         sh_q   <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         run_q  <= 1'b0;
         cnt_q  <= '0;
      end else if (go) begin
         acc_q  <= '0;
         sh_q   <= a;
         opnd_q <= b;
         div_q  <= is_div;
         run_q  <= 1'b1;
         cnt_q  <= '0;
      end else if (run_q) begin
         acc_q <= acc_d;
         sh_q  <= sh_d;
         cnt_q <= cnt_q + 1'b1;
         if (fin) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with start/busy/done handshake and HI/LO results.
// Define ALU_MULDIV_EN to build the iterative MULTU/DIVU core; otherwise 110/111 flag ill_op.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  option,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             ovf,
   output logic             ill_op
);

   state_t           state_q;
   logic [WIDTH-1:0] sum, diff;
   logic [WIDTH-1:0] res, hi_res;
   logic             ovf_res, ill_res;
   logic             start_iter;

   always_comb begin
      sum     = A + B;
      diff    = A - B;
      res     = '0;
      hi_res  = '0;
      ovf_res = 1'b0;
      ill_res = 1'b0;
      case (option)
         OP_ADD: begin
            res     = sum;
            ovf_res = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            res     = diff;
            ovf_res = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: res = A & B;
         OP_OR:  res = A | B;
         OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_XOR: res = A ^ B;
`ifdef ALU_MULDIV_EN
         // Only reached with B=0: product is 0, quotient saturates, remainder is A.
         OP_MULTU: res = '0;
         OP_DIVU: begin
            res    = '1;
            hi_res = A;
         end
`else
         OP_MULTU: ill_res = 1'b1;
         OP_DIVU:  ill_res = 1'b1;
`endif
         default: res = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic             core_fin;
   logic [WIDTH-1:0] core_lo, core_hi;

   assign start_iter = (option == OP_MULTU || option == OP_DIVU) && (B != '0);
   assign busy       = (state_q == ST_RUN);

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .go     (start && !busy && start_iter),
      .is_div (option == OP_DIVU),
      .a      (A),
      .b      (B),
      .fin    (core_fin),
      .lo     (core_lo),
      .hi     (core_hi)
   );
`else
   logic             core_fin;
   logic [WIDTH-1:0] core_lo, core_hi;

   assign start_iter = 1'b0;
   assign busy       = 1'b0;
   assign core_fin   = 1'b0;
   assign core_lo    = '0;
   assign core_hi    = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         done    <= 1'b0;
         out     <= '0;
         hi      <= '0;
         zero    <= 1'b0;
         ovf     <= 1'b0;
         ill_op  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (start_iter) begin
                     state_q <= ST_RUN;
                  end else begin
                     out    <= res;
                     hi     <= hi_res;
                     zero   <= (res == '0);
                     ovf    <= ovf_res;
                     ill_op <= ill_res;
                     done   <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (core_fin) begin
                  out     <= core_lo;
                  hi      <= core_hi;
                  zero    <= (core_lo == '0);
                  ovf     <= 1'b0;
                  ill_op  <= 1'b0;
                  done    <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
